// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches and buffers returned words.
// Optional same-cycle bypass of an empty queue when IFQ_BYPASS_EN is defined.
module ifetch_queue #(
  parameter int INST_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                imem_req,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INST_LEN-1:0] imem_rdata,
  output logic                out_valid,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [INST_LEN-1:0] out_instr,
  input  logic                out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d, disc_q, disc_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_LEN-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_LEN-1:0] pc_mem_q [DEPTH];
  logic [INST_LEN-1:0] ins_mem_q [DEPTH];
  logic rv_ok, accept, push, pop, head_valid, byp;

  // Request gating, bypass detection and head presentation
  always_comb begin
    imem_req = !reset && !redirect
      && ((32'(count_q) + 32'(outst_q)) < 32'(DEPTH))
      && (32'(outst_q) < 32'(MAX_OUTSTANDING));
    imem_addr = fetch_pc_q;
    count = count_q;
    rv_ok = imem_rvalid && (outst_q != '0);
    accept = imem_req && imem_gnt;
    head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    byp = !head_valid && (disc_q == '0)
      && !redirect && rv_ok;
`else
    byp = 1'b0;
`endif
    out_valid = head_valid || byp;
    out_pc = '0;
    out_instr = '0;
    if (head_valid) begin
      out_pc = pc_mem_q[rd_ptr_q];
      out_instr = ins_mem_q[rd_ptr_q];
    end else if (byp) begin
      out_pc = resp_pc_q;
      out_instr = imem_rdata;
    end
    pop = head_valid && out_ready && !redirect;
    push = rv_ok && (disc_q == '0) && !redirect
      && !(byp && out_ready);
  end

  // Next-state: redirect flushes, otherwise accept/response/pop bookkeeping
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d = count_q;
    disc_d = disc_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d = resp_pc_q;
    outst_d = outst_q + OW'(accept) - OW'(rv_ok);
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d = '0;
      fetch_pc_d = redirect_pc;
      resp_pc_d = redirect_pc;
      disc_d = outst_q - OW'(rv_ok);
    end else begin
      if (accept)
        fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
      if (rv_ok && disc_q != '0)
        disc_d = disc_q - OW'(1);
      if (rv_ok && disc_q == '0)
        resp_pc_d = resp_pc_q + ADDR_LEN'(4);
      if (push)
        wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      outst_q <= '0;
      disc_q <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      outst_q <= outst_d;
      disc_q <= disc_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
    end
  end

  // Entry storage; contents are only observed while counted as occupied
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q] <= resp_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end
endmodule
